// File: rtl/instr_fetch_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular FIFO of {PC, instruction}
// pairs. Push and pop use valid/ready handshakes, and flush empties the queue on a redirect.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 16,
  parameter int unsigned AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  input  logic [AW-1:0]            push_pc,
  input  logic [IW-1:0]            push_instr,
  output logic                     push_ready,
  output logic                     pop_valid,
  output logic [AW-1:0]            pop_pc,
  output logic [IW-1:0]            pop_instr,
  input  logic                     pop_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [AW-1:0] pc_mem    [DEPTH];
  logic [IW-1:0] instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_fire, pop_fire;

  // Handshake status comes from registered state only, so the PC stall has no input path.
  always_comb begin
    push_ready = (count_q != Full);
    pop_valid  = (count_q != '0);
    push_fire  = push_valid & push_ready;
    pop_fire   = pop_valid & pop_ready;
    count      = count_q;
    pop_pc     = '0;
    pop_instr  = '0;
    if (pop_valid) begin
      pop_pc    = pc_mem[rd_ptr_q];
      pop_instr = instr_mem[rd_ptr_q];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_fire && !pop_fire) begin
        count_d = count_q + CW'(1);
      end else if (pop_fire && !push_fire) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only slots between rd_ptr and wr_ptr are ever presented.
  always_ff @(posedge clk) begin
    if (push_fire && !flush) begin
      pc_mem[wr_ptr_q]    <= push_pc;
      instr_mem[wr_ptr_q] <= push_instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference of the FIFO contents.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 16;
  localparam int unsigned AW    = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          push_valid;
  logic [AW-1:0] push_pc;
  logic [IW-1:0] push_instr;
  logic          push_ready;
  logic          pop_valid;
  logic [AW-1:0] pop_pc;
  logic [IW-1:0] pop_instr;
  logic          pop_ready;
  logic [2:0]    count;

  int vectors    = 0;
  int miscompares = 0;

  ent_t exp_q[$];
  bit   pf, qf, fl;
  ent_t pend;

  instr_fetch_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push_valid(push_valid),
    .push_pc   (push_pc),
    .push_instr(push_instr),
    .push_ready(push_ready),
    .pop_valid (pop_valid),
    .pop_pc    (pop_pc),
    .pop_instr (pop_instr),
    .pop_ready (pop_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs to the reference, then note which handshakes fire at the next edge.
  always @(negedge clk) begin
    int sz;
    sz = exp_q.size();
    check("count", 64'(count), 64'(sz));
    check("push_ready", 64'(push_ready), 64'(sz < DEPTH));
    check("pop_valid", 64'(pop_valid), 64'(sz > 0));
    if (sz > 0) begin
      check("pop_pc", 64'(pop_pc), 64'(exp_q[0].pc));
      check("pop_instr", 64'(pop_instr), 64'(exp_q[0].instr));
    end else begin
      check("pop_pc_empty", 64'(pop_pc), 64'd0);
      check("pop_instr_empty", 64'(pop_instr), 64'd0);
    end
    pf   = push_valid && (sz < DEPTH);
    qf   = pop_ready && (sz > 0);
    fl   = flush;
    pend = '{pc: push_pc, instr: push_instr};
  end

  // Reference FIFO: flush empties it, otherwise pop the oldest and append the accepted word.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
    end else if (fl) begin
      exp_q.delete();
    end else begin
      if (qf) void'(exp_q.pop_front());
      if (pf) exp_q.push_back(pend);
    end
  end

  task automatic cyc(input bit pv, input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                     input bit pr, input bit fls);
    push_valid = pv;
    push_pc    = pc;
    push_instr = ins;
    pop_ready  = pr;
    flush      = fls;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_pop_valid", 64'(pop_valid), 64'd0);
    check("rst_pop_instr", 64'(pop_instr), 64'd0);
    check("rst_pop_pc", 64'(pop_pc), 64'd0);
    check("rst_push_ready", 64'(push_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] rpc;
    reset = 1'b0;
    flush = 1'b0;
    push_valid = 1'b0;
    push_pc = '0;
    push_instr = '0;
    pop_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset mid-stream with three entries held.
    for (int i = 0; i < 3; i++) cyc(1'b1, AW'(32'h10 + i), IW'(16'h9000 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd3);
    async_reset();

    // Fill, refused fifth offer, then drain.
    for (int i = 0; i < 4; i++) cyc(1'b1, AW'(32'h20 + i), IW'(16'hA000 + i), 1'b0, 1'b0);
    cyc(1'b1, AW'(32'h24), IW'(16'hA004), 1'b0, 1'b0);
    check("full_head_pc", 64'(pop_pc), 64'h20);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);

    // Steady stream: push and pop every cycle.
    for (int i = 0; i < 10; i++) cyc(1'b1, AW'(32'h20 + i), IW'(16'hA000 + i), 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with concurrent push and pop, then a lone push.
    for (int i = 0; i < 3; i++) cyc(1'b1, AW'(32'h50 + i), IW'(16'hC000 + i), 1'b0, 1'b0);
    cyc(1'b1, AW'(32'h30), IW'(16'hB030), 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    cyc(1'b1, AW'(32'h40), IW'(16'hB040), 1'b0, 1'b0);
    check("after_flush_head", 64'(pop_pc), 64'h40);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Full with push and pop offered together.
    for (int i = 0; i < 4; i++) cyc(1'b1, AW'(32'h60 + i), IW'(16'hD000 + i), 1'b0, 1'b0);
    cyc(1'b1, AW'(32'h64), IW'(16'hD004), 1'b1, 1'b0);
    check("full_pop_count", 64'(count), 64'd3);
    cyc(1'b1, AW'(32'h64), IW'(16'hD004), 1'b0, 1'b0);
    check("refill_count", 64'(count), 64'd4);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes and asynchronous resets.
    rpc = AW'(32'h1000);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      cyc($urandom_range(0, 3) != 0, rpc, IW'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 31) == 0);
      rpc = rpc + AW'(2);
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
